// File: rtl/norm_shift_unit_if.sv
// Request/result bundle between pipeline control and the multi-cycle normalizer.
interface norm_shift_unit_if;
   logic        start_i;
   logic        flush_i;
   logic [1:0]  opcode_i;
   logic [31:0] op_a_i;
   logic        busy_o;
   logic        done_o;
   logic [5:0]  amount_o;
   logic [31:0] value_o;

   modport master (
      output start_i, flush_i, opcode_i, op_a_i,
      input  busy_o, done_o, amount_o, value_o
   );

   modport slave (
      input  start_i, flush_i, opcode_i, op_a_i,
      output busy_o, done_o, amount_o, value_o
   );
endinterface

// File: rtl/norm_shift_unit.sv
// Multi-cycle CLZ/CTZ/CLS normalizer: one barrel stage (16,8,4,2,1) per cycle,
// returning the shift count and the normalized operand.
module norm_shift_unit #(
   parameter logic [31:0] UNKNOWN_OPCODE_RESULT = 32'h0
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   norm_shift_unit_if.slave   bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned K_W    = 5;

   localparam logic [1:0] OP_CLZ = 2'b00;
   localparam logic [1:0] OP_CTZ = 2'b01;
   localparam logic [1:0] OP_CLS = 2'b10;
   localparam logic [1:0] OP_UNK = 2'b11;

   typedef enum logic [2:0] {IDLE, S16, S8, S4, S2, S1} state_e;

   state_e              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [DATA_W-1:0]   tmp_q, tmp_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [CNT_W-1:0]    amount_q, amount_d;
   logic [DATA_W-1:0]   value_q, value_d;

   logic [K_W-1:0]      stage_k;
   logic [DATA_W-1:0]   cls_bits;
   logic [DATA_W-1:0]   cls_mask;
   logic                stage_hit;
   logic                fast_path;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         op_q     <= OP_CLZ;
         tmp_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         amount_q <= '0;
         value_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         tmp_q    <= tmp_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         amount_q <= amount_d;
         value_q  <= value_d;
      end
   end

   // Stage width and whether the current stage's shift condition holds.
   always_comb begin
      stage_k = '0;
      case (state_q)
         S16:     stage_k = K_W'(16);
         S8:      stage_k = K_W'(8);
         S4:      stage_k = K_W'(4);
         S2:      stage_k = K_W'(2);
         S1:      stage_k = K_W'(1);
         default: stage_k = '0;
      endcase

      // CLS examines the top k+1 bits, right-aligned, against all-zero or all-one.
      cls_bits = tmp_q >> (K_W'(31) - stage_k);
      cls_mask = (DATA_W'(1) << (stage_k + K_W'(1))) - DATA_W'(1);

      stage_hit = 1'b0;
      case (op_q)
         OP_CLZ:  stage_hit = ((tmp_q & ~({DATA_W{1'b1}} >> stage_k)) == '0);
         OP_CTZ:  stage_hit = ((tmp_q & ~({DATA_W{1'b1}} << stage_k)) == '0);
         OP_CLS:  stage_hit = (cls_bits == '0) || (cls_bits == cls_mask);
         default: stage_hit = 1'b0;
      endcase

      fast_path = (op_q == OP_UNK) ||
                  (((op_q == OP_CLZ) || (op_q == OP_CTZ)) && (tmp_q == '0));
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      tmp_d    = tmp_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      amount_d = amount_q;
      value_d  = value_q;

      if (state_q == IDLE) begin
         if (bus.start_i && !bus.flush_i) begin
            op_d    = bus.opcode_i;
            tmp_d   = bus.op_a_i;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S16;
         end
      end else if (bus.flush_i) begin
         busy_d  = 1'b0;
         state_d = IDLE;
      end else if ((state_q == S16) && fast_path) begin
         // Zero operand would only reach 31 through the stages, so finish early.
         amount_d = (op_q == OP_UNK) ? '0 : CNT_W'(32);
         value_d  = (op_q == OP_UNK) ? UNKNOWN_OPCODE_RESULT : '0;
         done_d   = 1'b1;
         busy_d   = 1'b0;
         state_d  = IDLE;
      end else begin
         if (stage_hit) begin
            tmp_d = (op_q == OP_CTZ) ? (tmp_q >> stage_k) : (tmp_q << stage_k);
            cnt_d = cnt_q + CNT_W'(stage_k);
         end
         case (state_q)
            S16:     state_d = S8;
            S8:      state_d = S4;
            S4:      state_d = S2;
            S2:      state_d = S1;
            default: begin
               amount_d = cnt_d;
               value_d  = tmp_d;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end
         endcase
      end
   end

   assign bus.busy_o   = busy_q;
   assign bus.done_o   = done_q;
   assign bus.amount_o = amount_q;
   assign bus.value_o  = value_q;
endmodule

// File: tb/tb_norm_shift_unit.sv
// Randomized and directed checks of norm_shift_unit against a bit-counting reference model.
module tb_norm_shift_unit;
   logic clk_i;
   logic rst_n_i;
   int   checks;
   int   errors;

   norm_shift_unit_if bus ();

   norm_shift_unit dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: count bits directly from the operation definitions.
   task automatic ref_op(input logic [1:0] opc, input logic [31:0] a,
                         output logic [5:0] amt, output logic [31:0] val, output int lat);
      int n;
      n = 0;
      lat = 5;
      case (opc)
         2'b00: begin
            if (a == 0) begin n = 32; lat = 1; end
            else for (int i = 31; i >= 0; i--) begin if (a[i]) break; n++; end
            val = (n == 32) ? 32'h0 : (a << n);
         end
         2'b01: begin
            if (a == 0) begin n = 32; lat = 1; end
            else for (int i = 0; i < 32; i++) begin if (a[i]) break; n++; end
            val = (n == 32) ? 32'h0 : (a >> n);
         end
         2'b10: begin
            for (int i = 30; i >= 0; i--) begin if (a[i] != a[31]) break; n++; end
            val = a << n;
         end
         default: begin n = 0; val = 32'h0; lat = 1; end
      endcase
      amt = 6'(n);
   endtask

   task automatic accept(input logic [1:0] opc, input logic [31:0] a);
      bus.start_i  = 1'b1;
      bus.opcode_i = opc;
      bus.op_a_i   = a;
      @(posedge clk_i); #1;
      bus.start_i  = 1'b0;
      bus.op_a_i   = $urandom;
   endtask

   // Called #1 after the accept edge; returns edges until done (0 on timeout).
   task automatic wait_done(output int lat, output int busy_cycles);
      lat = 0;
      busy_cycles = 0;
      for (int n = 1; n <= 10; n++) begin
         if (bus.busy_o) busy_cycles++;
         @(posedge clk_i); #1;
         if (bus.done_o) begin lat = n; break; end
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] opc, input logic [31:0] a);
      logic [5:0]  e_amt;
      logic [31:0] e_val;
      int e_lat, lat, bc;
      ref_op(opc, a, e_amt, e_val, e_lat);
      accept(opc, a);
      wait_done(lat, bc);
      check({tag, "_lat"}, 64'(lat), 64'(e_lat));
      check({tag, "_busy_cyc"}, 64'(bc), 64'(e_lat));
      check({tag, "_busy_at_done"}, 64'(bus.busy_o), 64'(0));
      check({tag, "_amount"}, 64'(bus.amount_o), 64'(e_amt));
      check({tag, "_value"}, 64'(bus.value_o), 64'(e_val));
      @(posedge clk_i); #1;
      check({tag, "_done_drop"}, 64'(bus.done_o), 64'(0));
      check({tag, "_hold"}, {26'h0, bus.amount_o, bus.value_o}, {26'h0, e_amt, e_val});
   endtask

   initial begin
      logic [5:0]  e_amt, p_amt;
      logic [31:0] e_val, p_val;
      logic [31:0] a;
      logic [1:0]  opc;
      int e_lat, lat, bc, dones;

      checks = 0;
      errors = 0;
      rst_n_i      = 1'b0;
      bus.start_i  = 1'b0;
      bus.flush_i  = 1'b0;
      bus.opcode_i = 2'b00;
      bus.op_a_i   = 32'h0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_outputs", {bus.busy_o, bus.done_o, bus.amount_o, bus.value_o}, 64'h0);
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;

      run_op("clz_10000",  2'b00, 32'h0001_0000);
      run_op("ctz_100",    2'b01, 32'h0000_0100);
      run_op("ctz_msb",    2'b01, 32'h8000_0000);
      run_op("cls_ffff8k", 2'b10, 32'hFFFF_8000);
      run_op("cls_zero",   2'b10, 32'h0000_0000);
      run_op("cls_ones",   2'b10, 32'hFFFF_FFFF);
      run_op("cls_4k",     2'b10, 32'h4000_0000);
      run_op("clz_zero",   2'b00, 32'h0000_0000);
      run_op("ctz_zero",   2'b01, 32'h0000_0000);
      run_op("unk_op",     2'b11, 32'h1234_5678);

      for (int i = 0; i < 40; i++) begin
         opc = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: a = $urandom;
            1: a = $urandom >> $urandom_range(0, 31);
            2: a = $urandom << $urandom_range(0, 31);
            default: a = ~($urandom >> $urandom_range(0, 31));
         endcase
         run_op("rand", opc, a);
      end

      // Start while busy is ignored: only one done, result of the first operand.
      accept(2'b00, 32'h0000_0001);
      @(posedge clk_i); #1;
      bus.start_i  = 1'b1;
      bus.op_a_i   = 32'h00F0_0000;
      @(posedge clk_i); #1;
      bus.start_i  = 1'b0;
      dones = 0;
      for (int n = 0; n < 10; n++) begin
         if (bus.done_o) begin
            dones++;
            check("busy_ign_amount", 64'(bus.amount_o), 64'd31);
            check("busy_ign_value", 64'(bus.value_o), 64'h8000_0000);
         end
         @(posedge clk_i); #1;
      end
      check("busy_ign_dones", 64'(dones), 64'd1);

      // Start held during the done cycle is accepted with no idle gap.
      accept(2'b01, 32'h0000_0030);
      wait_done(lat, bc);
      check("b2b_first_lat", 64'(lat), 64'd5);
      check("b2b_first_amount", 64'(bus.amount_o), 64'd4);
      bus.start_i  = 1'b1;
      bus.opcode_i = 2'b10;
      bus.op_a_i   = 32'h0000_0F00;
      @(posedge clk_i); #1;
      bus.start_i  = 1'b0;
      check("b2b_second_busy", {bus.busy_o, bus.done_o}, 64'b10);
      ref_op(2'b10, 32'h0000_0F00, e_amt, e_val, e_lat);
      wait_done(lat, bc);
      check("b2b_second_lat", 64'(lat), 64'(e_lat));
      check("b2b_second_result", {26'h0, bus.amount_o, bus.value_o}, {26'h0, e_amt, e_val});
      p_amt = e_amt;
      p_val = e_val;
      @(posedge clk_i); #1;

      // Flush in cycle 3: no done, previous results held.
      accept(2'b01, 32'h0000_0100);
      repeat (2) @(posedge clk_i);
      #1;
      bus.flush_i = 1'b1;
      @(posedge clk_i); #1;
      bus.flush_i = 1'b0;
      check("flush_busy", 64'(bus.busy_o), 64'd0);
      dones = 0;
      for (int n = 0; n < 8; n++) begin
         if (bus.done_o) dones++;
         @(posedge clk_i); #1;
      end
      check("flush_no_done", 64'(dones), 64'd0);
      check("flush_hold", {26'h0, bus.amount_o, bus.value_o}, {26'h0, p_amt, p_val});

      // Flush with start while idle blocks acceptance.
      bus.flush_i = 1'b1;
      accept(2'b00, 32'h0000_0001);
      bus.flush_i = 1'b0;
      check("flush_start_idle", 64'(bus.busy_o), 64'd0);

      // Reset mid-operation clears everything at that edge.
      accept(2'b00, 32'h0000_0001);
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b0;
      @(posedge clk_i); #1;
      check("rst_mid", {bus.busy_o, bus.done_o, bus.amount_o, bus.value_o}, 64'h0);
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      run_op("post_rst", 2'b00, 32'h0001_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
